vx_om_dcr_bank: RTL
===================

VX_OM_DCR_BANK -- requirements
Module: VX_om_dcr_bank

Interface
REQ-001 SHALL have parameter INSTANCE_ID, default "", trace-name string.
REQ-002 SHALL have parameter NUM_CTX, default 2, number of OM state contexts (1..8).
REQ-003 SHALL have parameter INFLIGHT_BITS, default 6, width of the per-context in-flight counter.
REQ-004 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port dcr_bus_if  VX_dcr_bus_if.slave  -  write_valid/write_addr/write_data, OM DCR writes.
REQ-007 SHALL have port write_ctx  input  CTX_BITS=max(1,clog2(NUM_CTX))  target context of the current DCR write.
REQ-008 SHALL have ports commit_valid/commit_ready  input/output  1/1  shadow-to-active commit handshake.
REQ-009 SHALL have port commit_ctx  input  CTX_BITS  context to commit.
REQ-010 SHALL have port commit_done  output  1  one-cycle pulse when the active copy is updated.
REQ-011 SHALL have ports acq_valid/acq_ready/acq_ctx  in/out/in  1/1/CTX_BITS  a fragment batch enters OM using a context.
REQ-012 SHALL have ports rel_valid/rel_ctx  input  1/CTX_BITS  a batch leaves OM (no backpressure).
REQ-013 SHALL have port rd_ctx  input  CTX_BITS  context selector for om_dcrs.
REQ-014 SHALL have port om_dcrs  output  om_dcrs_t  active state of rd_ctx, combinational mux of registered banks.
REQ-015 SHALL have port err_underflow  output  1  sticky; release seen with counter at zero.

Function
REQ-016 SHALL keep per context a shadow bank and an active bank of om_dcrs_t.
REQ-017 SHALL decode all OM DCR addresses (cbuf/zbuf addr/pitch/writemask, depth func/writemask, stencil func/zpass/zfail/fail/ref/mask/writemask front at [15:0], back at [31:16], blend mode, blend func, blend const, logic op) into shadow[write_ctx]; field slicing per VX_om_pkg widths; unknown addresses ignored.
REQ-018 SHALL NOT write derived enables into shadow; depth_enable, stencil_enable[1:0], blend_enable are computed only at commit from the full shadow contents (depth: ~(func==ALWAYS & ~writemask); stencil per face: ~(func==ALWAYS & zpass==KEEP & zfail==KEEP); blend: ~(both modes ADD & both src ONE & both dst ZERO)).
REQ-019 SHALL run FSM IDLE -> DRAIN -> COPY -> IDLE; commit_ready=1 only in IDLE; handshake captures commit_ctx into cctx and moves to DRAIN.
REQ-020 SHALL, in DRAIN, hold acq_ready=0 for acq_ctx==cctx, and move to COPY on the first cycle inflight[cctx]==0.
REQ-021 SHALL, in COPY, load active[cctx] from shadow[cctx] plus derived enables, pulse commit_done that same cycle, return to IDLE; total latency from commit handshake to commit_done = 2 cycles when drained.
REQ-022 SHALL give a DCR write to shadow[cctx] in the COPY cycle lower priority: active receives the pre-write shadow, shadow receives the write.
REQ-023 SHALL set acq_ready=0 for a context whose counter equals 2^INFLIGHT_BITS-1; otherwise 1 (subject to REQ-020).
REQ-024 SHALL increment inflight[c] on acq_valid&acq_ready, decrement on rel_valid; same-cycle acq and rel on c leave it unchanged.
REQ-025 SHALL ignore rel_valid when inflight[rel_ctx]==0 (no wrap) and set err_underflow.
REQ-026 SHALL leave other contexts fully operational (acquire/release/write) during a commit to cctx.
REQ-027 SHALL treat out-of-range ctx indices (>=NUM_CTX) as no-ops for writes, commits (accepted, completes with no update) and acq/rel.

Reset
REQ-028 SHALL, on reset_n low, asynchronously clear all shadow and active fields to 0, all counters to 0, FSM to IDLE, commit_done=0, err_underflow=0; commit_ready=1 and acq_ready=1 after release.
REQ-029 SHALL abandon an in-progress commit on reset with no active-bank update.

Verification
REQ-030 SHALL verify: write DEPTH_FUNC=ALWAYS then DEPTH_WRITEMASK=0 to ctx0, commit ctx0 with no in-flight -> commit_done 2 cycles later, om_dcrs(rd_ctx=0).depth_enable=0.
REQ-031 SHALL verify: 3 acquires on ctx1, commit ctx1, releases at cycles +5,+6,+7 -> acq_ready(ctx1)=0 during drain, commit_done at +9, active unchanged before it.
REQ-032 SHALL verify: BLEND_CONST=0xAABBCCDD to ctx1 in the COPY cycle of ctx1 commit -> active keeps old value, shadow holds 0xAABBCCDD, visible after next commit.
REQ-033 SHALL verify: 63 acquires on ctx0 (INFLIGHT_BITS=6) -> acq_ready=0; same-cycle acq+rel keeps count 63; rel at 0 -> err_underflow=1 sticky.
REQ-034 SHALL verify: reset_n pulse during DRAIN -> all outputs to reset values, no commit_done, commit_ready=1.

Source files
------------

// File: rtl/vx_om_dcr_bank.sv
// OM DCR bank: per-context shadow/active output-merger state, drain-then-copy commit,
// and per-context in-flight batch accounting.

package vx_om_pkg;
    localparam int DCR_ADDR_BITS = 12;
    localparam int DCR_DATA_BITS = 32;

    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_CBUF_ADDR         = 12'h010;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_CBUF_PITCH        = 12'h011;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_CBUF_WRITEMASK    = 12'h012;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_ZBUF_ADDR         = 12'h013;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_ZBUF_PITCH        = 12'h014;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_DEPTH_FUNC        = 12'h015;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_DEPTH_WRITEMASK   = 12'h016;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_STENCIL_FUNC      = 12'h017;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_STENCIL_ZPASS     = 12'h018;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_STENCIL_ZFAIL     = 12'h019;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_STENCIL_FAIL      = 12'h01A;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_STENCIL_REF       = 12'h01B;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_STENCIL_MASK      = 12'h01C;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_STENCIL_WRITEMASK = 12'h01D;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_BLEND_MODE        = 12'h01E;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_BLEND_FUNC        = 12'h01F;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_BLEND_CONST       = 12'h020;
    localparam logic [DCR_ADDR_BITS-1:0] DCR_OM_LOGIC_OP          = 12'h021;

    localparam logic [2:0] OM_DEPTH_FUNC_ALWAYS = 3'd7;
    localparam logic [2:0] OM_STENCIL_OP_KEEP   = 3'd0;
    localparam logic [2:0] OM_BLEND_MODE_ADD    = 3'd0;
    localparam logic [3:0] OM_BLEND_FUNC_ZERO   = 4'd0;
    localparam logic [3:0] OM_BLEND_FUNC_ONE    = 4'd1;

    typedef struct packed {
        logic [31:0]      cbuf_addr;
        logic [31:0]      cbuf_pitch;
        logic [3:0]       cbuf_writemask;
        logic [31:0]      zbuf_addr;
        logic [31:0]      zbuf_pitch;
        logic             depth_enable;
        logic [2:0]       depth_func;
        logic             depth_writemask;
        logic [1:0]       stencil_enable;
        logic [1:0][2:0]  stencil_func;
        logic [1:0][2:0]  stencil_zpass;
        logic [1:0][2:0]  stencil_zfail;
        logic [1:0][2:0]  stencil_fail;
        logic [1:0][7:0]  stencil_ref;
        logic [1:0][7:0]  stencil_mask;
        logic [1:0][7:0]  stencil_writemask;
        logic             blend_enable;
        logic [2:0]       blend_mode_rgb;
        logic [2:0]       blend_mode_a;
        logic [3:0]       blend_src_rgb;
        logic [3:0]       blend_src_a;
        logic [3:0]       blend_dst_rgb;
        logic [3:0]       blend_dst_a;
        logic [31:0]      blend_const;
        logic [3:0]       logic_op;
    } om_dcrs_t;
endpackage

interface VX_dcr_bus_if;
    logic                                write_valid;
    logic [vx_om_pkg::DCR_ADDR_BITS-1:0] write_addr;
    logic [vx_om_pkg::DCR_DATA_BITS-1:0] write_data;

    modport master (output write_valid, output write_addr, output write_data);
    modport slave  (input  write_valid, input  write_addr, input  write_data);
endinterface

module vx_om_dcr_bank
    import vx_om_pkg::*;
#(
    parameter string INSTANCE_ID   = "",
    parameter int    NUM_CTX       = 2,
    parameter int    INFLIGHT_BITS = 6,
    localparam int   CTX_BITS      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    VX_dcr_bus_if.slave         dcr_bus_if,
    input  logic [CTX_BITS-1:0] write_ctx,
    input  logic                commit_valid,
    output logic                commit_ready,
    input  logic [CTX_BITS-1:0] commit_ctx,
    output logic                commit_done,
    input  logic                acq_valid,
    output logic                acq_ready,
    input  logic [CTX_BITS-1:0] acq_ctx,
    input  logic                rel_valid,
    input  logic [CTX_BITS-1:0] rel_ctx,
    input  logic [CTX_BITS-1:0] rd_ctx,
    output om_dcrs_t            om_dcrs,
    output logic                err_underflow
);

    localparam logic [INFLIGHT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_COPY
    } state_e;

    if (INSTANCE_ID == "") begin : g_anon_instance
    end

    state_e                   state_q, state_d;
    logic [CTX_BITS-1:0]      cctx_q, cctx_d;
    logic                     err_q, err_d;
    om_dcrs_t                 shadow_q   [NUM_CTX];
    om_dcrs_t                 shadow_d   [NUM_CTX];
    om_dcrs_t                 active_q   [NUM_CTX];
    om_dcrs_t                 active_d   [NUM_CTX];
    logic [INFLIGHT_BITS-1:0] inflight_q [NUM_CTX];
    logic [INFLIGHT_BITS-1:0] inflight_d [NUM_CTX];

    logic [INFLIGHT_BITS-1:0] acq_cnt, rel_cnt, cctx_cnt;
    logic                     acq_hit, rel_hit;
    logic                     rel_take, rel_underflow;
    logic                     acq_full, acq_block, acq_fire;

    function automatic om_dcrs_t apply_write(
        input om_dcrs_t                 s,
        input logic [DCR_ADDR_BITS-1:0] addr,
        input logic [DCR_DATA_BITS-1:0] data
    );
        om_dcrs_t r;
        r = s;
        case (addr)
            DCR_OM_CBUF_ADDR:      r.cbuf_addr       = data;
            DCR_OM_CBUF_PITCH:     r.cbuf_pitch      = data;
            DCR_OM_CBUF_WRITEMASK: r.cbuf_writemask  = data[3:0];
            DCR_OM_ZBUF_ADDR:      r.zbuf_addr       = data;
            DCR_OM_ZBUF_PITCH:     r.zbuf_pitch      = data;
            DCR_OM_DEPTH_FUNC:     r.depth_func      = data[2:0];
            DCR_OM_DEPTH_WRITEMASK: r.depth_writemask = data[0];
            DCR_OM_STENCIL_FUNC: begin
                r.stencil_func[0] = data[2:0];
                r.stencil_func[1] = data[18:16];
            end
            DCR_OM_STENCIL_ZPASS: begin
                r.stencil_zpass[0] = data[2:0];
                r.stencil_zpass[1] = data[18:16];
            end
            DCR_OM_STENCIL_ZFAIL: begin
                r.stencil_zfail[0] = data[2:0];
                r.stencil_zfail[1] = data[18:16];
            end
            DCR_OM_STENCIL_FAIL: begin
                r.stencil_fail[0] = data[2:0];
                r.stencil_fail[1] = data[18:16];
            end
            DCR_OM_STENCIL_REF: begin
                r.stencil_ref[0] = data[7:0];
                r.stencil_ref[1] = data[23:16];
            end
            DCR_OM_STENCIL_MASK: begin
                r.stencil_mask[0] = data[7:0];
                r.stencil_mask[1] = data[23:16];
            end
            DCR_OM_STENCIL_WRITEMASK: begin
                r.stencil_writemask[0] = data[7:0];
                r.stencil_writemask[1] = data[23:16];
            end
            DCR_OM_BLEND_MODE: begin
                r.blend_mode_rgb = data[2:0];
                r.blend_mode_a   = data[18:16];
            end
            DCR_OM_BLEND_FUNC: begin
                r.blend_src_rgb = data[3:0];
                r.blend_src_a   = data[11:8];
                r.blend_dst_rgb = data[19:16];
                r.blend_dst_a   = data[27:24];
            end
            DCR_OM_BLEND_CONST:    r.blend_const = data;
            DCR_OM_LOGIC_OP:       r.logic_op    = data[3:0];
            default: ;
        endcase
        return r;
    endfunction

    // Enables depend on several registers, so they are only meaningful once the whole
    // shadow is settled; they are derived here, at commit time, and never from a write.
    function automatic om_dcrs_t with_enables(input om_dcrs_t s);
        om_dcrs_t r;
        r = s;
        r.depth_enable = ~((s.depth_func == OM_DEPTH_FUNC_ALWAYS) & ~s.depth_writemask);
        for (int f = 0; f < 2; f++) begin
            r.stencil_enable[f] = ~((s.stencil_func[f]  == OM_DEPTH_FUNC_ALWAYS)
                                  & (s.stencil_zpass[f] == OM_STENCIL_OP_KEEP)
                                  & (s.stencil_zfail[f] == OM_STENCIL_OP_KEEP));
        end
        r.blend_enable = ~((s.blend_mode_rgb == OM_BLEND_MODE_ADD)
                         & (s.blend_mode_a   == OM_BLEND_MODE_ADD)
                         & (s.blend_src_rgb  == OM_BLEND_FUNC_ONE)
                         & (s.blend_src_a    == OM_BLEND_FUNC_ONE)
                         & (s.blend_dst_rgb  == OM_BLEND_FUNC_ZERO)
                         & (s.blend_dst_a    == OM_BLEND_FUNC_ZERO));
        return r;
    endfunction

    // Context lookups; an index with no matching context reads as zero / not present.
    always_comb begin
        acq_cnt  = '0;
        rel_cnt  = '0;
        cctx_cnt = '0;
        acq_hit  = 1'b0;
        rel_hit  = 1'b0;
        om_dcrs  = '0;
        for (int c = 0; c < NUM_CTX; c++) begin
            if (acq_ctx == CTX_BITS'(c)) begin
                acq_cnt = inflight_q[c];
                acq_hit = 1'b1;
            end
            if (rel_ctx == CTX_BITS'(c)) begin
                rel_cnt = inflight_q[c];
                rel_hit = 1'b1;
            end
            if (cctx_q == CTX_BITS'(c)) begin
                cctx_cnt = inflight_q[c];
            end
            if (rd_ctx == CTX_BITS'(c)) begin
                om_dcrs = active_q[c];
            end
        end
    end

    // A full counter still accepts an acquire when the same context releases this cycle.
    always_comb begin
        rel_take      = rel_valid & rel_hit & (rel_cnt != '0);
        rel_underflow = rel_valid & rel_hit & (rel_cnt == '0);
        acq_full      = acq_hit & (acq_cnt == CNT_MAX) & ~(rel_take & (rel_ctx == acq_ctx));
        acq_block     = (state_q == ST_DRAIN) & (acq_ctx == cctx_q);
        acq_ready     = ~acq_full & ~acq_block;
        acq_fire      = acq_valid & acq_ready & acq_hit;
        commit_ready  = (state_q == ST_IDLE);
        commit_done   = (state_q == ST_COPY);
        err_underflow = err_q;
    end

    always_comb begin
        state_d    = state_q;
        cctx_d     = cctx_q;
        err_d      = err_q | rel_underflow;
        shadow_d   = shadow_q;
        active_d   = active_q;
        inflight_d = inflight_q;

        case (state_q)
            ST_IDLE: begin
                if (commit_valid) begin
                    cctx_d  = commit_ctx;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cctx_cnt == '0) begin
                    state_d = ST_COPY;
                end
            end
            ST_COPY:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Active copies the registered shadow, so a write landing in the copy cycle
        // reaches only the shadow and waits for the next commit.
        for (int c = 0; c < NUM_CTX; c++) begin
            if ((state_q == ST_COPY) && (cctx_q == CTX_BITS'(c))) begin
                active_d[c] = with_enables(shadow_q[c]);
            end
            if (dcr_bus_if.write_valid && (write_ctx == CTX_BITS'(c))) begin
                shadow_d[c] = apply_write(shadow_q[c], dcr_bus_if.write_addr,
                                          dcr_bus_if.write_data);
            end
            case ({acq_fire & (acq_ctx == CTX_BITS'(c)), rel_take & (rel_ctx == CTX_BITS'(c))})
                2'b10:   inflight_d[c] = inflight_q[c] + INFLIGHT_BITS'(1);
                2'b01:   inflight_d[c] = inflight_q[c] - INFLIGHT_BITS'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cctx_q  <= '0;
            err_q   <= 1'b0;
            for (int c = 0; c < NUM_CTX; c++) begin
                shadow_q[c]   <= '0;
                active_q[c]   <= '0;
                inflight_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cctx_q     <= cctx_d;
            err_q      <= err_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            inflight_q <= inflight_d;
        end
    end

endmodule
